// File: rtl/btb_sat.sv
// ============================================================================
//  Module   : btb_sat
//  Summary  : Direct-mapped branch target buffer with per-entry N-bit
//             saturating direction counters and a predicted next-pc output.
//  Options  : BTB_STATS_EN adds lookup / hit / mispredict statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_sat #(
  parameter int PC_W     = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            rd_en,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_hit,
  output logic            rd_taken,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [PC_W-1:0] wr_target,
  input  logic            wr_taken,
  input  logic            flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int c_idx_w = $clog2(ENTRIES);
  localparam int c_tag_w = PC_W - c_idx_w - 2;

  localparam logic [CNT_BITS-1:0] c_cnt_max = '1;
  localparam logic [CNT_BITS-1:0] c_cnt_wt  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] c_cnt_wnt = c_cnt_wt - CNT_BITS'(1);

  logic [ENTRIES-1:0]  r_valid;
  logic [c_tag_w-1:0]  r_tag    [ENTRIES];
  logic [PC_W-1:0]     r_target [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];

  logic [c_idx_w-1:0]  w_rd_idx;
  logic [c_tag_w-1:0]  w_rd_tag;
  logic                w_rd_hit;
  logic                w_rd_taken;

  logic [c_idx_w-1:0]  w_wr_idx;
  logic [c_tag_w-1:0]  w_wr_tag;
  logic                w_wr_hit;
  logic [CNT_BITS-1:0] w_wr_cnt;
  logic [CNT_BITS-1:0] w_cnt_inc;
  logic [CNT_BITS-1:0] w_cnt_dec;

  // Lookup path: purely combinational, reads pre-edge state (no bypass).
  assign w_rd_idx   = rd_pc[c_idx_w+1:2];
  assign w_rd_tag   = rd_pc[PC_W-1:c_idx_w+2];
  assign w_rd_hit   = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign w_rd_taken = w_rd_hit && r_cnt[w_rd_idx][CNT_BITS-1];

  assign rd_hit    = w_rd_hit;
  assign rd_taken  = w_rd_taken;
  assign rd_target = w_rd_taken ? r_target[w_rd_idx] : (rd_pc + PC_W'(4));

  assign w_wr_idx  = wr_pc[c_idx_w+1:2];
  assign w_wr_tag  = wr_pc[PC_W-1:c_idx_w+2];
  assign w_wr_hit  = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
  assign w_wr_cnt  = r_cnt[w_wr_idx];
  assign w_cnt_inc = (w_wr_cnt == c_cnt_max) ? w_wr_cnt : (w_wr_cnt + CNT_BITS'(1));
  assign w_cnt_dec = (w_wr_cnt == '0)        ? w_wr_cnt : (w_wr_cnt - CNT_BITS'(1));

  // Flush only drops valid bits; tag/target/cnt linger but are unreachable.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= c_cnt_wnt;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (wr_en) begin
      if (w_wr_hit) begin
        if (wr_taken) begin
          r_cnt[w_wr_idx]    <= w_cnt_inc;
          r_target[w_wr_idx] <= wr_target;
        end else begin
          r_cnt[w_wr_idx]    <= w_cnt_dec;
        end
      end else if (wr_taken) begin
        r_valid[w_wr_idx]  <= 1'b1;
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= wr_target;
        r_cnt[w_wr_idx]    <= c_cnt_wt;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic r_unused_dummy;
  logic w_mispredict;
  logic w_unused;

  // Mispredicts are judged against the pre-update prediction, flush or not.
  assign w_mispredict = wr_en && ((w_wr_hit && w_wr_cnt[CNT_BITS-1]) != wr_taken);
  assign w_unused     = ^{rd_pc[1:0], wr_pc[1:0], r_unused_dummy};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
      r_unused_dummy   <= 1'b0;
    end else begin
      if (rd_en && (stat_lookups != 32'hFFFF_FFFF))
        stat_lookups <= stat_lookups + 32'd1;
      if (rd_en && w_rd_hit && (stat_hits != 32'hFFFF_FFFF))
        stat_hits <= stat_hits + 32'd1;
      if (w_mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{rd_en, rd_pc[1:0], wr_pc[1:0]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_btb_sat.sv
// Directed bench for btb_sat: a table-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
`default_nettype none

module tb_btb_sat;

  localparam int NE   = 16;
  localparam int CMAX = 3;
  localparam int CHALF = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_pc = 32'h40;
  logic        rd_hit;
  logic        rd_taken;
  logic [31:0] rd_target;
  logic        wr_en = 1'b0;
  logic [31:0] wr_pc = '0;
  logic [31:0] wr_target = '0;
  logic        wr_taken = 1'b0;
  logic        flush = 1'b0;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;
`endif

  int ntests = 0;
  int nfail  = 0;

  btb_sat #(.PC_W(32), .ENTRIES(NE), .CNT_BITS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .rd_en(rd_en), .rd_pc(rd_pc), .rd_hit(rd_hit), .rd_taken(rd_taken), .rd_target(rd_target),
    .wr_en(wr_en), .wr_pc(wr_pc), .wr_target(wr_target), .wr_taken(wr_taken),
    .flush(flush)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: a plain table of entries, addressed by word index.
  bit          m_valid [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_cnt   [NE];
  logic [31:0] m_lk, m_ht, m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= CHALF);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] <= 1'b0;
        m_tag[i]   <= '0;
        m_tgt[i]   <= '0;
        m_cnt[i]   <= CHALF - 1;
      end
      m_lk <= '0;
      m_ht <= '0;
      m_mp <= '0;
    end else begin
      if (rd_en && m_lk != 32'hFFFF_FFFF) m_lk <= m_lk + 1;
      if (rd_en && m_hit(rd_pc) && m_ht != 32'hFFFF_FFFF) m_ht <= m_ht + 1;
      if (wr_en && (m_pred(wr_pc) != wr_taken) && m_mp != 32'hFFFF_FFFF) m_mp <= m_mp + 1;
      if (flush) begin
        for (int i = 0; i < NE; i++) m_valid[i] <= 1'b0;
      end else if (wr_en) begin
        if (m_hit(wr_pc)) begin
          if (wr_taken) begin
            m_cnt[m_idx(wr_pc)] <= (m_cnt[m_idx(wr_pc)] < CMAX) ? m_cnt[m_idx(wr_pc)] + 1 : CMAX;
            m_tgt[m_idx(wr_pc)] <= wr_target;
          end else begin
            m_cnt[m_idx(wr_pc)] <= (m_cnt[m_idx(wr_pc)] > 0) ? m_cnt[m_idx(wr_pc)] - 1 : 0;
          end
        end else if (wr_taken) begin
          m_valid[m_idx(wr_pc)] <= 1'b1;
          m_tag[m_idx(wr_pc)]   <= wr_pc >> 6;
          m_tgt[m_idx(wr_pc)]   <= wr_target;
          m_cnt[m_idx(wr_pc)]   <= CHALF;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (nRST) begin
      chk("model_hit",    {31'd0, rd_hit},   {31'd0, m_hit(rd_pc)});
      chk("model_taken",  {31'd0, rd_taken}, {31'd0, m_pred(rd_pc)});
      chk("model_target", rd_target,         m_next(rd_pc));
`ifdef BTB_STATS_EN
      chk("model_lookups",  stat_lookups,     m_lk);
      chk("model_hits",     stat_hits,        m_ht);
      chk("model_mispred",  stat_mispredicts, m_mp);
`endif
    end
  end

  task automatic cyc(input logic en, input logic [31:0] rpc, input logic we,
                     input logic [31:0] wpc, input logic [31:0] wt, input logic wtk,
                     input logic fl);
    @(posedge CLK);
    #1;
    rd_en = en; rd_pc = rpc; wr_en = we; wr_pc = wpc;
    wr_target = wt; wr_taken = wtk; flush = fl;
  endtask

  task automatic look(input logic [31:0] rpc);
    cyc(1'b0, rpc, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic lit(input string name, input logic h, input logic t, input logic [31:0] tg);
    @(negedge CLK);
    chk({name, "_hit"},    {31'd0, rd_hit},   {31'd0, h});
    chk({name, "_taken"},  {31'd0, rd_taken}, {31'd0, t});
    chk({name, "_target"}, rd_target,         tg);
  endtask

  task automatic cntchk(input string name, input int exp);
    chk(name, 32'(m_cnt[0]), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    lit("reset", 1'b0, 1'b0, 32'h44);

    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    lit("no_bypass", 1'b0, 1'b0, 32'h44);
    look(32'h40);
    lit("alloc", 1'b1, 1'b1, 32'h100);
    cntchk("cnt_alloc", 2);

    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    lit("pre_nt1", 1'b1, 1'b1, 32'h100);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    lit("cnt1", 1'b1, 1'b0, 32'h44);
    cntchk("cnt_1", 1);
    look(32'h40);
    lit("cnt0", 1'b1, 1'b0, 32'h44);
    cntchk("cnt_0", 0);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    @(negedge CLK) cntchk("cnt_sat_low", 0);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    @(negedge CLK) cntchk("cnt_up1", 1);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    lit("cnt_up2", 1'b1, 1'b1, 32'h100);
    cntchk("cnt_up2_m", 2);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    @(negedge CLK) cntchk("cnt_up3", 3);
    look(32'h40);
    lit("cnt_sat_high", 1'b1, 1'b1, 32'h100);
    cntchk("cnt_sat_high_m", 3);

    cyc(1'b0, 32'h80, 1'b1, 32'h80, 32'h200, 1'b0, 1'b0);
    lit("alias_pre", 1'b0, 1'b0, 32'h84);
    look(32'h80);
    lit("alias_nt_miss", 1'b0, 1'b0, 32'h84);
    look(32'h42);
    lit("low_bits_ignored", 1'b1, 1'b1, 32'h100);
    cyc(1'b0, 32'h40, 1'b1, 32'h80, 32'h200, 1'b1, 1'b0);
    lit("replace_pre", 1'b1, 1'b1, 32'h100);
    look(32'h80);
    lit("replace_new", 1'b1, 1'b1, 32'h200);
    look(32'h40);
    lit("replace_old", 1'b0, 1'b0, 32'h44);
    look(32'hFFFF_FFFC);
    lit("wrap", 1'b0, 1'b0, 32'h0);

    cyc(1'b0, 32'h44, 1'b1, 32'h44, 32'h300, 1'b1, 1'b0);
    cyc(1'b0, 32'h44, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    lit("idx1", 1'b1, 1'b1, 32'h300);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h500, 1'b1, 1'b1);
    lit("flush_pre", 1'b1, 1'b1, 32'h100);
    look(32'h40);
    lit("flush_40", 1'b0, 1'b0, 32'h44);
    look(32'h44);
    lit("flush_44", 1'b0, 1'b0, 32'h48);
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h600, 1'b1, 1'b0);
    look(32'h40);
    lit("realloc", 1'b1, 1'b1, 32'h600);

    // Fresh reset, then a short run that exercises the statistics counters.
    @(posedge CLK);
    #1;
    nRST = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    cyc(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    lit("st_b", 1'b1, 1'b1, 32'h100);
    cyc(1'b1, 32'h40, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    lit("st_d", 1'b1, 1'b0, 32'h44);
    cyc(1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h44, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    look(32'h40);
`ifdef BTB_STATS_EN
    @(negedge CLK);
    chk("stat_lookups", stat_lookups, 32'd5);
    chk("stat_hits", stat_hits, 32'd3);
    chk("stat_mispredicts", stat_mispredicts, 32'd2);
    cyc(1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    look(32'h40);
    @(negedge CLK);
    chk("stat_lookups_flush", stat_lookups, 32'd5);
    chk("stat_hits_flush", stat_hits, 32'd3);
    chk("stat_mispredicts_flush", stat_mispredicts, 32'd2);
`endif
    look(32'h40);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btb_sat.md
Name: btb_sat

Overview:
- Parametrised branch target buffer for the pipelined MIPS core. It succeeds the fixed single-bit BTB.
- Direct-mapped, with configurable entry count and an N-bit saturating direction counter per entry.
- Combinational lookup in decode from the IF/ID pc. Registered update in execute when the branch resolves.
- Also supplies a predicted next-pc, so the pc block can consume the prediction directly.

Parameters:
- PC_W, 32, pc and target width in bits.
- ENTRIES, 16, number of BTB entries. Power of two, >= 2.
- CNT_BITS, 2, width of each saturating direction counter (1..4).

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- rd_en  in  1  lookup qualifier (decode stage holds a valid branch candidate)
- rd_pc  in  PC_W  pc of the instruction being looked up
- rd_hit  out  1  entry valid and tag matches rd_pc
- rd_taken  out  1  prediction: hit and counter MSB = 1
- rd_target  out  PC_W  predicted next pc: stored target if rd_taken, else rd_pc+4
- wr_en  in  1  resolved branch update from execute
- wr_pc  in  PC_W  pc of the resolved branch
- wr_target  in  PC_W  resolved branch target address
- wr_taken  in  1  actual outcome of the resolved branch
- flush  in  1  synchronous invalidate of all entries

Behaviour:
- Derived widths:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[PC_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Per-entry state: valid (1), tag, target (PC_W), cnt (CNT_BITS).
- Reset (nRST=0, asynchronous):
  - all valid=0, tag=0, target=0.
  - cnt = 2^(CNT_BITS-1)-1 (weakly not-taken).
- Lookup:
  - Purely combinational; zero-cycle latency; independent of rd_en.
  - rd_hit = valid[idx] & (tag[idx]==rd_tag).
  - rd_taken = rd_hit & cnt[idx][CNT_BITS-1].
  - rd_target = rd_taken ? target[idx] : rd_pc+4, truncated to PC_W (wraps at max pc).
  - After reset: rd_hit=0, rd_taken=0, rd_target=rd_pc+4.
- Update (rising edge, wr_en=1, flush=0), with wr_hit = valid & tag match at wr_pc's index:
  - wr_hit & wr_taken: cnt saturating +1 (max 2^CNT_BITS-1); target <= wr_target.
  - wr_hit & !wr_taken: cnt saturating -1 (min 0); target unchanged.
  - !wr_hit & wr_taken: allocate, replacing any aliasing entry. valid=1, tag=wr_tag, target=wr_target, cnt = 2^(CNT_BITS-1) (weakly taken).
  - !wr_hit & !wr_taken: no state change.
- Simultaneous lookup and update to the same index:
  - Lookup sees pre-edge state. There is no write-to-read bypass.
  - The new state is visible the cycle after the edge.
- flush=1:
  - All valid bits clear at the next edge.
  - tag, target and cnt are retained but unreachable.
  - flush overrides a wr_en in the same cycle; that update is discarded.
- No backpressure or handshake: exactly one update is accepted per cycle with wr_en.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds outputs stat_lookups (32), stat_hits (32) and stat_mispredicts (32).
  - stat_lookups increments each cycle with rd_en=1.
  - stat_hits increments each cycle with rd_en & rd_hit.
  - stat_mispredicts increments when wr_en=1 and the pre-update prediction for wr_pc (hit & cnt MSB) differs from wr_taken. This applies even if flush is high that cycle.
  - All counters saturate at 32'hFFFFFFFF, reset to 0 on nRST, and are unaffected by flush.
- Not defined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset, rd_pc=32'h0000_0040 -> rd_hit=0, rd_taken=0, rd_target=32'h0000_0044.
- wr_en, wr_pc=0x40, wr_target=0x100, wr_taken=1, then lookup 0x40 -> next cycle rd_hit=1, rd_taken=1, rd_target=0x100, cnt=2.
- Two further not-taken updates at 0x40 -> cnt 2->1->0. Lookup gives rd_hit=1, rd_taken=0, rd_target=0x44. Another not-taken keeps cnt=0. Three taken updates give cnt 1, 2, 3, and a fourth keeps cnt=3.
- ENTRIES=16: after the 0x40 allocation, not-taken update at 0x80 (same index 0) -> no change, and lookup 0x80 misses. Taken update at 0x80 (target 0x200) -> replaces the entry, and lookup 0x40 now misses.
- Same cycle: flush=1 and wr_en taken at 0x40 -> next cycle every lookup misses, and the update is lost.
- With BTB_STATS_EN: 5 rd_en cycles, 3 of them hitting, and 2 mispredicted updates -> stat_lookups=5, stat_hits=3, stat_mispredicts=2. A following flush leaves the values unchanged.
